// File: rtl/tff_count_ctrl_if.sv
// Command channel between the command source and tff_count_ctrl.
// Valid/ready handshake plus the operation fields latched at accept.
interface tff_count_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_steps;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_steps,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_steps,
    output cmd_ready
  );
endinterface

// File: rtl/tff_count_ctrl.sv
// Sequencer turning UP/DOWN/LOAD/CLEAR commands into one-cycle toggle pulses for a TFF bank.
// Optional shadow-check of the bank value is enabled by defining TFF_CTRL_VERIFY_EN.
module tff_count_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  tff_count_ctrl_if.slave  cmd,
  input  logic             abort,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] t_out,
  output logic             busy,
  output logic             done,
  output logic             wrapped,
  output logic             aborted,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, CALC, PULSE, DONE} state_t;
  typedef enum logic [1:0] {OP_UP, OP_DOWN, OP_LOAD, OP_CLEAR} op_t;

  state_t           state, state_nx;
  op_t              op;
  op_t              cmd_op_e;
  logic [WIDTH-1:0] data;
  logic [CNT_W-1:0] steps;
  logic [CNT_W-1:0] steps_dec;
  logic [WIDTH-1:0] t_calc;
  logic             accept;
  logic             wrap_now;

  assign cmd_op_e      = op_t'(cmd.cmd_op);
  assign accept        = cmd.cmd_valid && (state == IDLE);
  assign cmd.cmd_ready = (state == IDLE);
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign steps_dec     = steps - CNT_W'(1);
  assign wrap_now      = ((op == OP_UP) && (&q_in)) || ((op == OP_DOWN) && !(|q_in));

  // Toggle bit i flips when every lower bit is 1 (up) or 0 (down): ripple carry/borrow.
  always_comb begin
    logic run_up;
    logic run_dn;
    t_calc = '0;
    run_up = 1'b1;
    run_dn = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      case (op)
        OP_UP:   t_calc[i] = run_up;
        OP_DOWN: t_calc[i] = run_dn;
        OP_LOAD: t_calc[i] = q_in[i] ^ data[i];
        default: t_calc[i] = q_in[i];
      endcase
      run_up = run_up & q_in[i];
      run_dn = run_dn & ~q_in[i];
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (((cmd_op_e == OP_UP) || (cmd_op_e == OP_DOWN)) && (cmd.cmd_steps == '0))
            state_nx = DONE;
          else
            state_nx = CALC;
        end
      end
      CALC:  state_nx = abort ? DONE : PULSE;
      PULSE: begin
        if (((op == OP_UP) || (op == OP_DOWN)) && (steps_dec != '0))
          state_nx = CALC;
        else
          state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op      <= OP_UP;
      data    <= '0;
      steps   <= '0;
      t_out   <= '0;
      wrapped <= 1'b0;
      aborted <= 1'b0;
    end else begin
      t_out <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            op      <= cmd_op_e;
            data    <= cmd.cmd_data;
            steps   <= cmd.cmd_steps;
            wrapped <= 1'b0;
            aborted <= 1'b0;
          end
        end
        CALC: begin
          if (abort) begin
            aborted <= 1'b1;
          end else begin
            t_out <= t_calc;
            if (wrap_now) wrapped <= 1'b1;
          end
        end
        PULSE:   steps <= steps_dec;
        default: ;
      endcase
    end
  end

`ifdef TFF_CTRL_VERIFY_EN
  logic [WIDTH-1:0] shadow;
  logic             pulsed;
  logic             err_q;
  logic             mismatch;

  // The first CALC has no prior pulse to check against, so gate on pulsed.
  assign mismatch = (state == CALC) && pulsed && (q_in != shadow);
  assign err      = err_q | mismatch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      pulsed <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        shadow <= q_in;
        pulsed <= 1'b0;
      end else if (state == PULSE) begin
        shadow <= shadow ^ t_out;
        pulsed <= 1'b1;
      end
      if (mismatch) err_q <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Bench for tff_count_ctrl driving a behavioural TFF bank; pulses are scored against expected queues.
// Cycle k means the k-th clock period after the accepting edge; all sampling is on the falling edge.
module tb_tff_count_ctrl;

  localparam logic [1:0] UP = 2'b00, DOWN = 2'b01, LOAD = 2'b10, CLEAR = 2'b11;

  typedef struct packed {
    logic [7:0] cyc;
    logic [3:0] t;
  } pulse_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       abort;
  logic [3:0] bank, qforce, q_in, t_out;
  logic       busy, done, wrapped, aborted, err;

  int checks   = 0;
  int failures = 0;

  pulse_t sb[$];
  pulse_t obs[$];

  tff_count_ctrl_if #(.WIDTH(4), .CNT_W(8)) cif ();

  tff_count_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .cmd     (cif),
    .abort   (abort),
    .q_in    (q_in),
    .t_out   (t_out),
    .busy    (busy),
    .done    (done),
    .wrapped (wrapped),
    .aborted (aborted),
    .err     (err)
  );

  always #5 clk = ~clk;

  assign q_in = bank | qforce;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bank <= '0;
    else     bank <= bank ^ t_out;
  end

  function automatic pulse_t pop_sb();
    pulse_t p;
    p = 12'hfff;
    if (sb.size() > 0) p = sb.pop_front();
    return p;
  endfunction

  function automatic pulse_t pop_obs();
    pulse_t p;
    p = 12'hfff;
    if (obs.size() > 0) p = obs.pop_front();
    return p;
  endfunction

  function automatic void push_sb(input int c, input logic [3:0] t);
    pulse_t p;
    p.cyc = 8'(c);
    p.t   = t;
    sb.push_back(p);
  endfunction

  // Issues one command and steps until done (bounded), recording observed pulses and err per cycle.
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] data, input logic [7:0] steps,
                         input int ab_from, input int ab_to, input bit spam, input int force_cyc,
                         output int done_cyc, output logic [63:0] errs);
    pulse_t p;
    @(negedge clk);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_data  = data;
    cif.cmd_steps = steps;
    @(posedge clk);
    #1;
    cif.cmd_valid = 1'b0;
    done_cyc = -1;
    errs = '0;
    for (int c = 1; c < 60; c++) begin
      @(negedge clk);
      abort = (c >= ab_from) && (c <= ab_to);
      if (c == force_cyc) qforce = 4'b1000;
      #1;
      errs[c] = err;
      if (t_out !== 4'b0000) begin
        p.cyc = 8'(c);
        p.t   = t_out;
        obs.push_back(p);
      end
      if (done === 1'b1) begin
        done_cyc = c;
        cif.cmd_valid = 1'b0;
        break;
      end
      cif.cmd_valid = spam;
      cif.cmd_op    = CLEAR;
      cif.cmd_data  = 4'($urandom);
      cif.cmd_steps = 8'd1;
    end
    abort = 1'b0;
  endtask

  task automatic test_reset;
    int n_done;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({t_out, cif.cmd_ready, busy, done, wrapped, aborted, err} !== 10'b0000_100000) begin
      failures++;
      $display("FAIL reset_held got=%b exp=%b", {t_out, cif.cmd_ready, busy, done, wrapped, aborted, err}, 10'b0000_100000);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({t_out, cif.cmd_ready, busy, done, wrapped, aborted, err} !== 10'b0000_100000) begin
      failures++;
      $display("FAIL reset_released got=%b exp=%b", {t_out, cif.cmd_ready, busy, done, wrapped, aborted, err}, 10'b0000_100000);
    end
    // Reset in the middle of a pulse: t_out must drop without waiting for a clock.
    cif.cmd_valid = 1'b1; cif.cmd_op = UP; cif.cmd_steps = 8'd3; cif.cmd_data = 4'd0;
    @(posedge clk);
    #1 cif.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (t_out !== 4'b0001) begin
      failures++;
      $display("FAIL reset_mid_pulse_pre got=%b exp=%b", t_out, 4'b0001);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({t_out, busy} !== 5'b0000_0) begin
      failures++;
      $display("FAIL reset_async got=%b exp=%b", {t_out, busy}, 5'b0000_0);
    end
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    checks++;
    if (n_done != 0) begin
      failures++;
      $display("FAIL reset_no_done got=%0d exp=0", n_done);
    end
  endtask

  task automatic test_up_count;
    int dc;
    logic [63:0] e;
    pulse_t a, x;
    push_sb(2, 4'b0001); push_sb(4, 4'b0011); push_sb(6, 4'b0001);
    run_cmd(UP, 4'd0, 8'd3, 0, 0, 1'b1, 0, dc, e);
    checks++;
    if (dc != 7) begin failures++; $display("FAIL up3_done_cycle got=%0d exp=7", dc); end
    checks++;
    if ({cif.cmd_ready, busy, wrapped} !== 3'b010) begin
      failures++; $display("FAIL up3_flags_at_done got=%b exp=010", {cif.cmd_ready, busy, wrapped});
    end
    @(negedge clk);
    checks++;
    if ({cif.cmd_ready, busy, done, bank} !== 7'b100_0011) begin
      failures++; $display("FAIL up3_after got=%b exp=%b", {cif.cmd_ready, busy, done, bank}, 7'b100_0011);
    end
    while (sb.size() > 0 || obs.size() > 0) begin
      x = pop_sb(); a = pop_obs();
      checks++;
      if (a !== x) begin failures++; $display("FAIL up3_pulse got=%0d:%b exp=%0d:%b", a.cyc, a.t, x.cyc, x.t); end
    end
  endtask

  task automatic test_up_wrap;
    int dc;
    logic [63:0] e;
    pulse_t a, x;
    push_sb(2, 4'b1101);
    run_cmd(LOAD, 4'b1110, 8'd0, 0, 0, 1'b0, 0, dc, e);
    checks++;
    if (dc != 3) begin failures++; $display("FAIL load_pre_done got=%0d exp=3", dc); end
    push_sb(2, 4'b0001); push_sb(4, 4'b1111);
    run_cmd(UP, 4'd0, 8'd2, 0, 0, 1'b0, 0, dc, e);
    checks++;
    if (dc != 5) begin failures++; $display("FAIL upwrap_done got=%0d exp=5", dc); end
    checks++;
    if ({wrapped, aborted, bank} !== 6'b10_0000) begin
      failures++; $display("FAIL upwrap_state got=%b exp=%b", {wrapped, aborted, bank}, 6'b10_0000);
    end
    while (sb.size() > 0 || obs.size() > 0) begin
      x = pop_sb(); a = pop_obs();
      checks++;
      if (a !== x) begin failures++; $display("FAIL upwrap_pulse got=%0d:%b exp=%0d:%b", a.cyc, a.t, x.cyc, x.t); end
    end
  endtask

  task automatic test_down_load;
    int dc;
    logic [63:0] e;
    pulse_t a, x;
    push_sb(2, 4'b1111);
    run_cmd(DOWN, 4'd0, 8'd1, 0, 0, 1'b0, 0, dc, e);
    checks++;
    if ({dc == 3, wrapped, bank} !== 6'b11_1111) begin
      failures++; $display("FAIL down_wrap got=%0d/%b/%b exp=3/1/1111", dc, wrapped, bank);
    end
    push_sb(2, 4'b1001);
    run_cmd(LOAD, 4'b0110, 8'd9, 0, 0, 1'b0, 0, dc, e);
    checks++;
    if ({wrapped, bank} !== 5'b0_0110) begin
      failures++; $display("FAIL load_wrap_clear got=%b exp=%b", {wrapped, bank}, 5'b0_0110);
    end
    push_sb(2, 4'b1100);
    run_cmd(LOAD, 4'b1010, 8'd0, 0, 0, 1'b0, 0, dc, e);
    checks++;
    if (dc != 3 || bank !== 4'b1010) begin
      failures++; $display("FAIL load_1010 got=%0d/%b exp=3/1010", dc, bank);
    end
    while (sb.size() > 0 || obs.size() > 0) begin
      x = pop_sb(); a = pop_obs();
      checks++;
      if (a !== x) begin failures++; $display("FAIL download_pulse got=%0d:%b exp=%0d:%b", a.cyc, a.t, x.cyc, x.t); end
    end
  endtask

  task automatic test_abort;
    int dc;
    logic [63:0] e;
    pulse_t a, x;
    push_sb(2, 4'b1010);
    run_cmd(CLEAR, 4'b0101, 8'd0, 0, 0, 1'b0, 0, dc, e);
    checks++;
    if (dc != 3 || bank !== 4'b0000) begin
      failures++; $display("FAIL clear got=%0d/%b exp=3/0000", dc, bank);
    end
    push_sb(2, 4'b0001); push_sb(4, 4'b0011);
    run_cmd(UP, 4'd0, 8'd10, 4, 5, 1'b0, 0, dc, e);
    checks++;
    if (dc != 6) begin failures++; $display("FAIL abort_done got=%0d exp=6", dc); end
    checks++;
    if ({aborted, wrapped, bank} !== 6'b10_0010) begin
      failures++; $display("FAIL abort_state got=%b exp=%b", {aborted, wrapped, bank}, 6'b10_0010);
    end
    // Zero steps completes at once; a no-change LOAD still spends its pulse cycle with t_out=0.
    run_cmd(DOWN, 4'd0, 8'd0, 0, 0, 1'b0, 0, dc, e);
    checks++;
    if ({dc == 1, aborted} !== 2'b10) begin
      failures++; $display("FAIL steps0 got=%0d/%b exp=1/0", dc, aborted);
    end
    run_cmd(LOAD, 4'b0010, 8'd0, 0, 0, 1'b0, 0, dc, e);
    checks++;
    if (dc != 3 || bank !== 4'b0010) begin
      failures++; $display("FAIL load_equal got=%0d/%b exp=3/0010", dc, bank);
    end
    while (sb.size() > 0 || obs.size() > 0) begin
      x = pop_sb(); a = pop_obs();
      checks++;
      if (a !== x) begin failures++; $display("FAIL abort_pulse got=%0d:%b exp=%0d:%b", a.cyc, a.t, x.cyc, x.t); end
    end
  endtask

  task automatic test_random_mix;
    int dc, exp_dc;
    logic [63:0] e;
    logic [3:0] qm, t, d;
    logic [1:0] op;
    logic [7:0] st;
    logic wrap_m;
    pulse_t a, x;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    qm = 4'd0;
    for (int n = 0; n < 10; n++) begin
      op = 2'($urandom_range(0, 3));
      d  = 4'($urandom);
      st = 8'($urandom_range(0, 5));
      wrap_m = 1'b0;
      if (op == UP || op == DOWN) begin
        for (int k = 0; k < int'(st); k++) begin
          if ((op == UP && qm == 4'hf) || (op == DOWN && qm == 4'h0)) wrap_m = 1'b1;
          t = (op == UP) ? (qm ^ (qm + 4'd1)) : (qm ^ (qm - 4'd1));
          push_sb(2 + 2 * k, t);
          qm = qm ^ t;
        end
        exp_dc = (st == 0) ? 1 : 2 * int'(st) + 1;
      end else begin
        t = (op == LOAD) ? (qm ^ d) : qm;
        if (t != 4'd0) push_sb(2, t);
        qm = (op == LOAD) ? d : 4'd0;
        exp_dc = 3;
      end
      run_cmd(op, d, st, 0, 0, 1'b0, 0, dc, e);
      checks++;
      if (dc != exp_dc || wrapped !== wrap_m || bank !== qm) begin
        failures++;
        $display("FAIL rand_cmd%0d op=%0d got=%0d/%b/%b exp=%0d/%b/%b", n, op, dc, wrapped, bank, exp_dc, wrap_m, qm);
      end
      while (sb.size() > 0 || obs.size() > 0) begin
        x = pop_sb(); a = pop_obs();
        checks++;
        if (a !== x) begin failures++; $display("FAIL rand_pulse got=%0d:%b exp=%0d:%b", a.cyc, a.t, x.cyc, x.t); end
      end
    end
  endtask

  task automatic test_verify;
    int dc;
    logic [63:0] e;
    logic exp_err;
    pulse_t a, x;
`ifdef TFF_CTRL_VERIFY_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    push_sb(2, 4'b0001); push_sb(4, 4'b0011);
    run_cmd(UP, 4'd0, 8'd2, 0, 0, 1'b0, 2, dc, e);
    checks++;
    if (dc != 5) begin failures++; $display("FAIL verify_done got=%0d exp=5", dc); end
    checks++;
    if ({e[1], e[2], e[3], e[4], e[5]} !== {1'b0, 1'b0, exp_err, exp_err, exp_err}) begin
      failures++; $display("FAIL verify_err_trace got=%b exp=%b", {e[1], e[2], e[3], e[4], e[5]}, {1'b0, 1'b0, exp_err, exp_err, exp_err});
    end
    repeat (3) @(negedge clk);
    checks++;
    if (err !== exp_err) begin failures++; $display("FAIL verify_err_sticky got=%b exp=%b", err, exp_err); end
    qforce = 4'b0000;
    rst = 1'b1;
    #1;
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL verify_err_reset got=%b exp=0", err); end
    @(negedge clk); rst = 1'b0;
    while (sb.size() > 0 || obs.size() > 0) begin
      x = pop_sb(); a = pop_obs();
      checks++;
      if (a !== x) begin failures++; $display("FAIL verify_pulse got=%0d:%b exp=%0d:%b", a.cyc, a.t, x.cyc, x.t); end
    end
  endtask

  initial begin
    rst = 1'b1;
    abort = 1'b0;
    qforce = 4'b0000;
    cif.cmd_valid = 1'b0;
    cif.cmd_op = UP;
    cif.cmd_data = 4'd0;
    cif.cmd_steps = 8'd0;
    test_reset();
    test_up_count();
    test_up_wrap();
    test_down_load();
    test_abort();
    test_random_mix();
    test_verify();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
